// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the two-port memory arbiter.
package mem_arb_pkg;

    localparam int unsigned MEM_ARB_DEPTH = 16;
    localparam int unsigned MEM_ARB_WIDTH = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input arbiter: round-robin with a last-granted pointer, or fixed priority
// (requester 0 first) when MEM_ARB_FIXED_PRIO_EN is defined.
module rr_arbiter2 (
`ifndef MEM_ARB_FIXED_PRIO_EN
    input  logic clock,
    input  logic reset,
    input  logic i_upd,
    input  logic i_upd_id,
`endif
    input  logic i_req0,
    input  logic i_req1,
    output logic o_pick_c
);

`ifdef MEM_ARB_FIXED_PRIO_EN

    assign o_pick_c = !i_req0 && i_req1;

`else

    logic r_last;

    // Reset to 1 so requester 0 wins the first tie.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_last <= 1'b1;
        end else if (i_upd) begin
            r_last <= i_upd_id;
        end
    end

    always_comb begin
        o_pick_c = 1'b0;
        if (i_req0 && i_req1) begin
            o_pick_c = ~r_last;
        end else if (i_req1) begin
            o_pick_c = 1'b1;
        end
    end

`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates two requesters onto a single-port RAM (IDLE/ISSUE/WAIT/RESP).
// Build option: MEM_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned DEPTH  = MEM_ARB_DEPTH,
    parameter int unsigned WIDTH  = MEM_ARB_WIDTH,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [WIDTH-1:0]  wdata0,
    input  logic [WIDTH-1:0]  wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [WIDTH-1:0]  rdata,
    output logic              mem_write,
    output logic [WIDTH-1:0]  mem_datain,
    output logic [ADDR_W-1:0] mem_addr_w,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_addr_r,
    input  logic [WIDTH-1:0]  mem_dataout
);

    arb_state_e        r_state;
    arb_state_e        w_state_nxt;
    logic              w_take;
    logic              w_any;
    logic              w_pick;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [WIDTH-1:0]  w_sel_wdata;

    logic              r_id;
    logic              r_we;
    logic              r_gnt0;
    logic              r_gnt1;
    logic              r_rvalid0;
    logic              r_rvalid1;
    logic [WIDTH-1:0]  r_rdata;
    logic              r_mem_write;
    logic              r_mem_read;
    logic [WIDTH-1:0]  r_mem_datain;
    logic [ADDR_W-1:0] r_mem_addr_w;
    logic [ADDR_W-1:0] r_mem_addr_r;

    assign w_any       = req0 || req1;
    assign w_sel_we    = w_pick ? we1    : we0;
    assign w_sel_addr  = w_pick ? addr1  : addr0;
    assign w_sel_wdata = w_pick ? wdata1 : wdata0;

`ifdef MEM_ARB_FIXED_PRIO_EN
    rr_arbiter2 u_arb (
        .i_req0   (req0),
        .i_req1   (req1),
        .o_pick_c (w_pick)
    );
`else
    rr_arbiter2 u_arb (
        .clock    (clock),
        .reset    (reset),
        .i_upd    (r_state == ST_ISSUE),
        .i_upd_id (r_id),
        .i_req0   (req0),
        .i_req1   (req1),
        .o_pick_c (w_pick)
    );
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_take      = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: w_state_nxt = r_we ? ST_IDLE : ST_WAIT;
            ST_WAIT:  w_state_nxt = ST_RESP;
            ST_RESP:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are loaded on the edge entering the state in which they are visible.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_id         <= 1'b0;
            r_we         <= 1'b0;
            r_gnt0       <= 1'b0;
            r_gnt1       <= 1'b0;
            r_rvalid0    <= 1'b0;
            r_rvalid1    <= 1'b0;
            r_rdata      <= '0;
            r_mem_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_datain <= '0;
            r_mem_addr_w <= '0;
            r_mem_addr_r <= '0;
        end else begin
            r_gnt0      <= w_take && !w_pick;
            r_gnt1      <= w_take && w_pick;
            r_mem_write <= w_take && w_sel_we;
            r_mem_read  <= w_take && !w_sel_we;
            r_rvalid0   <= (r_state == ST_WAIT) && !r_id;
            r_rvalid1   <= (r_state == ST_WAIT) && r_id;
            if (w_take) begin
                r_id <= w_pick;
                r_we <= w_sel_we;
                if (w_sel_we) begin
                    r_mem_addr_w <= w_sel_addr;
                    r_mem_datain <= w_sel_wdata;
                end else begin
                    r_mem_addr_r <= w_sel_addr;
                end
            end
            if (r_state == ST_WAIT) begin
                r_rdata <= mem_dataout;
            end
        end
    end

    assign gnt0       = r_gnt0;
    assign gnt1       = r_gnt1;
    assign rvalid0    = r_rvalid0;
    assign rvalid1    = r_rvalid1;
    assign rdata      = r_rdata;
    assign mem_write  = r_mem_write;
    assign mem_read   = r_mem_read;
    assign mem_datain = r_mem_datain;
    assign mem_addr_w = r_mem_addr_w;
    assign mem_addr_r = r_mem_addr_r;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DEPTH, default 16, number of RAM words.
REQ-002 Parameter WIDTH, default 6, data word width in bits.
REQ-003 Parameter ADDR_W, default 4, address width, equal to clog2(DEPTH).
REQ-004 clock  in  1  the single clock; all state updates on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset, sampled on the rising clock edge.
REQ-006 req0 / req1  in  1  access request from requester 0 / 1.
REQ-007 we0 / we1  in  1  1 = write, 0 = read; qualifies reqN.
REQ-008 addr0 / addr1  in  ADDR_W  word address of requester 0 / 1.
REQ-009 wdata0 / wdata1  in  WIDTH  write data of requester 0 / 1.
REQ-010 gnt0 / gnt1  out  1  one-cycle grant pulse to requester 0 / 1.
REQ-011 rvalid0 / rvalid1  out  1  one-cycle read-data-valid pulse to requester 0 / 1.
REQ-012 rdata  out  WIDTH  read data, shared by both requesters, qualified by rvalidN.
REQ-013 mem_write, mem_datain[WIDTH], mem_addr_w[ADDR_W]  out  write port of the attached RAM.
REQ-014 mem_read, mem_addr_r[ADDR_W]  out  read port of the attached RAM.
REQ-015 mem_dataout  in  WIDTH  RAM read data, valid in the cycle after the edge that samples mem_read.

Function
REQ-016 The FSM SHALL have states IDLE, ISSUE, WAIT and RESP.
REQ-017 IDLE: if any reqN is high, latch the winner's we/addr/wdata and go to ISSUE; otherwise stay in IDLE.
REQ-018 ISSUE (1 cycle): assert gntN of the winner, drive mem_write or mem_read with the latched address/data, then write → IDLE, read → WAIT.
REQ-019 WAIT (1 cycle): register mem_dataout into rdata, then → RESP.
REQ-020 RESP (1 cycle): assert rvalidN of the winner with rdata stable, then → IDLE.
REQ-021 Latency from req sampled in IDLE at edge N: gnt and mem strobe in cycle N+1, rvalid in cycle N+3; a write occupies 2 cycles and a read 4 cycles, including IDLE.
REQ-022 Requests SHALL be sampled only in IDLE; a requester holds req/we/addr/wdata until its gnt, and drops req in the gnt cycle unless it wants another access.
REQ-023 A req withdrawn before it is sampled SHALL produce no gnt and no memory access.
REQ-024 Arbitration is round-robin: on simultaneous requests the requester not granted last wins; the last-granted pointer updates in ISSUE.
REQ-025 A single requesting side SHALL win regardless of the pointer.
REQ-026 mem_write and mem_read SHALL never both be high, and each SHALL be high only in ISSUE.
REQ-027 At most one of gnt0/gnt1, and at most one of rvalid0/rvalid1, SHALL be high in any cycle.
REQ-028 A read following a write to the same address SHALL return the newly written value.

Reset
REQ-029 While reset is high: state = IDLE; gnt0/1, rvalid0/1, mem_write and mem_read = 0; rdata, mem_datain, mem_addr_w and mem_addr_r = 0; last-granted pointer = 1, so requester 0 wins the first tie.
REQ-030 Reset in ISSUE, WAIT or RESP SHALL abort the access, and no rvalid SHALL follow.

Configuration
REQ-031 Macro MEM_ARB_FIXED_PRIO_EN.
- Defined: requester 0 always wins simultaneous requests and the pointer is not implemented.
- Undefined: round-robin per REQ-024.

Structure
REQ-032 Package mem_arb_pkg SHALL hold the state enum and the DEPTH/WIDTH default constants.
REQ-033 Sub-module rr_arbiter2 SHALL hold the two-input pick logic and the pointer (fixed-priority under the macro); the FSM stays in mem_arbiter.

Verification
REQ-034 Reset, then req0 writes 2 to addr 0 → gnt0 one cycle after sampling, with mem_write=1, mem_addr_w=0, mem_datain=2.
REQ-035 req0 reads addr 0 → mem_read=1 in the gnt cycle, and rvalid0=1 with rdata=2 two cycles later.
REQ-036 req0 and req1 write 10 and 11 to addr 5 in the same cycle after reset → gnt0 first, then gnt1; a subsequent read of addr 5 returns 11 (with MEM_ARB_FIXED_PRIO_EN the order is also 0 then 1).
REQ-037 Both requesters hold continuous reads → grants alternate 0,1,0,1; with MEM_ARB_FIXED_PRIO_EN only gnt0 is seen.
REQ-038 Write 7 to addr 15, then a read of addr 15 with reset asserted in WAIT → no rvalid, all outputs 0 next cycle, FSM in IDLE.
REQ-039 req1 raised then dropped while FSM is busy with requester 0 → no gnt1 and no memory access for requester 1.
